// File: rtl/register_addr_ctr_pkg.sv
// register_addr_pkg: shared types and constants for the address register slice.
//   op_e      - operation applied to the register value at a clock edge
//   MODE_WRAP - modulo-2^WIDTH arithmetic
//   MODE_SAT  - clamp at 0 / 2^WIDTH-1
package register_addr_pkg;

    typedef enum logic [2:0] {
        OP_HOLD    = 3'd0,
        OP_LOAD    = 3'd1,
        OP_RESTORE = 3'd2,
        OP_ADD     = 3'd3,
        OP_INC     = 3'd4,
        OP_DEC     = 3'd5
    } op_e;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage

// File: rtl/register_addr_ctr_if.sv
// register_addr_ctr_if: control and bus signals of the address register.
// Control inputs are active-low; bus enables are active-high.
//   load_xfer, add_off, inc, dec, clr_ovf  - operation requests
//   offset_in                              - signed relative offset
//   xfer_in                                - transfer bus data in
//   assert_addr, assert_xfer               - bus drive requests
//   addr_out, xfer_out, addr_en, xfer_en   - bus outputs
//   ovf                                    - sticky overflow flag
//   save, restore                          - only with REGISTER_ADDR_SHADOW_EN
// master: the controlling side (CPU sequencer); slave: the register.
interface register_addr_ctr_if #(
    parameter int WIDTH        = 16,
    parameter int OFFSET_WIDTH = 8
);
    logic                    load_xfer;
    logic                    add_off;
    logic                    inc;
    logic                    dec;
    logic                    clr_ovf;
    logic [OFFSET_WIDTH-1:0] offset_in;
    logic [WIDTH-1:0]        xfer_in;
    logic                    assert_addr;
    logic                    assert_xfer;
    logic [WIDTH-1:0]        addr_out;
    logic [WIDTH-1:0]        xfer_out;
    logic                    addr_en;
    logic                    xfer_en;
    logic                    ovf;
`ifdef REGISTER_ADDR_SHADOW_EN
    logic                    save;
    logic                    restore;
`endif

    modport master (
        output load_xfer, add_off, inc, dec, clr_ovf, offset_in, xfer_in,
               assert_addr, assert_xfer,
`ifdef REGISTER_ADDR_SHADOW_EN
        output save, restore,
`endif
        input  addr_out, xfer_out, addr_en, xfer_en, ovf
    );

    modport slave (
        input  load_xfer, add_off, inc, dec, clr_ovf, offset_in, xfer_in,
               assert_addr, assert_xfer,
`ifdef REGISTER_ADDR_SHADOW_EN
        input  save, restore,
`endif
        output addr_out, xfer_out, addr_en, xfer_en, ovf
    );

endinterface

// File: rtl/register_addr_ctr_alu.sv
// register_addr_alu: combinational next-value computation.
//   value   - current register value
//   op      - selected operation
//   offset  - signed relative offset (sign-extended internally)
//   xfer_in - load data
//   shadow  - restore data
//   next    - value to register at the edge
//   ovf_set - strobe: the arithmetic result left [0, 2^WIDTH-1]
module register_addr_alu
    import register_addr_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int STEP         = 1,
    parameter int OFFSET_WIDTH = 8,
    parameter int SATURATE     = MODE_WRAP
) (
    input  logic [WIDTH-1:0]        value,
    input  op_e                     op,
    input  logic [OFFSET_WIDTH-1:0] offset,
    input  logic [WIDTH-1:0]        xfer_in,
    input  logic [WIDTH-1:0]        shadow,
    output logic [WIDTH-1:0]        next,
    output logic                    ovf_set
);

    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    logic [WIDTH:0] w_val_x;
    logic [WIDTH:0] w_off_x;
    logic [WIDTH:0] w_sum;
    logic           w_arith;
    logic           w_up;

    assign w_val_x = {1'b0, value};
    assign w_off_x = {{(WIDTH+1-OFFSET_WIDTH){offset[OFFSET_WIDTH-1]}}, offset};

    always_comb begin
        w_sum   = w_val_x;
        w_arith = 1'b0;
        w_up    = 1'b1;
        case (op)
            OP_ADD: begin
                w_sum   = w_val_x + w_off_x;
                w_arith = 1'b1;
                w_up    = ~offset[OFFSET_WIDTH-1];
            end
            OP_INC: begin
                w_sum   = w_val_x + STEP_X;
                w_arith = 1'b1;
                w_up    = 1'b1;
            end
            OP_DEC: begin
                w_sum   = w_val_x - STEP_X;
                w_arith = 1'b1;
                w_up    = 1'b0;
            end
            default: ;
        endcase
    end

    // Bit WIDTH of the (WIDTH+1)-bit result flags leaving the range; the
    // direction (carry vs borrow) is known from the operation itself.
    always_comb begin
        next    = value;
        ovf_set = 1'b0;
        case (op)
            OP_LOAD:    next = xfer_in;
            OP_RESTORE: next = shadow;
            default: begin
                if (w_arith) begin
                    ovf_set = w_sum[WIDTH];
                    if (w_sum[WIDTH] && (SATURATE == MODE_SAT))
                        next = w_up ? '1 : '0;
                    else
                        next = w_sum[WIDTH-1:0];
                end
            end
        endcase
    end

endmodule

// File: rtl/register_addr_ctr.sv
// register_addr_ctr: parametrised address register (PC/SP/index) for the
// address and transfer buses. Load, inc/dec by STEP, signed-offset add,
// wrap or saturate arithmetic, sticky overflow flag.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high; value <= DEFAULT_VALUE, ovf <= 0
//   bus   - register_addr_ctr_if.slave (controls, data, bus outputs)
// Optional: define REGISTER_ADDR_SHADOW_EN to add save/restore and a
// shadow register for interrupt entry/return.
// Operation priority: load_xfer > restore > add_off > inc > dec > hold.
module register_addr_ctr
    import register_addr_pkg::*;
#(
    parameter int               WIDTH         = 16,
    parameter logic [WIDTH-1:0] DEFAULT_VALUE = '0,
    parameter int               STEP          = 1,
    parameter int               OFFSET_WIDTH  = 8,
    parameter int               SATURATE      = MODE_WRAP
) (
    input  logic               clk,
    input  logic               reset,
    register_addr_ctr_if.slave bus
);

    logic [WIDTH-1:0] r_value;
    logic             r_ovf;
    logic [WIDTH-1:0] w_shadow;
    logic [WIDTH-1:0] w_next;
    logic             w_ovf_set;
    op_e              w_op;

    always_comb begin
        w_op = OP_HOLD;
        if (!bus.load_xfer)
            w_op = OP_LOAD;
`ifdef REGISTER_ADDR_SHADOW_EN
        else if (!bus.restore)
            w_op = OP_RESTORE;
`endif
        else if (!bus.add_off)
            w_op = OP_ADD;
        else if (!bus.inc)
            w_op = OP_INC;
        else if (!bus.dec)
            w_op = OP_DEC;
    end

    register_addr_alu #(
        .WIDTH        (WIDTH),
        .STEP         (STEP),
        .OFFSET_WIDTH (OFFSET_WIDTH),
        .SATURATE     (SATURATE)
    ) u_alu (
        .value   (r_value),
        .op      (w_op),
        .offset  (bus.offset_in),
        .xfer_in (bus.xfer_in),
        .shadow  (w_shadow),
        .next    (w_next),
        .ovf_set (w_ovf_set)
    );

    // A new overflow on the same edge as clr_ovf keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= DEFAULT_VALUE;
            r_ovf   <= 1'b0;
        end else begin
            r_value <= w_next;
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (!bus.clr_ovf)
                r_ovf <= 1'b0;
        end
    end

`ifdef REGISTER_ADDR_SHADOW_EN
    logic [WIDTH-1:0] r_shadow;

    // Captures the pre-op value, independent of whatever op runs this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_shadow <= DEFAULT_VALUE;
        else if (!bus.save)
            r_shadow <= r_value;
    end

    assign w_shadow = r_shadow;
`else
    assign w_shadow = '0;
`endif

    assign bus.addr_out = r_value;
    assign bus.xfer_out = r_value;
    assign bus.ovf      = r_ovf;
    assign bus.addr_en  = ~bus.assert_addr;
    assign bus.xfer_en  = ~bus.assert_xfer;

endmodule

// File: tb/tb_register_addr_ctr.sv
// tb_register_addr_ctr: directed vectors for register_addr_ctr.
// dut0: wrap mode, STEP=1, reset value 0.
// dut1: saturate mode, STEP=4, reset value 16'hFFFC.
// Define REGISTER_ADDR_SHADOW_EN to also exercise save/restore on dut0.
module tb_register_addr_ctr;
    import register_addr_pkg::*;

    logic clk;
    logic reset;
    int unsigned n_cmp;
    int unsigned n_err;
    int unsigned en_pat;

    register_addr_ctr_if #(.WIDTH(16), .OFFSET_WIDTH(8)) bus0 ();
    register_addr_ctr_if #(.WIDTH(16), .OFFSET_WIDTH(8)) bus1 ();

    register_addr_ctr #(
        .WIDTH         (16),
        .DEFAULT_VALUE (16'h0000),
        .STEP          (1),
        .OFFSET_WIDTH  (8),
        .SATURATE      (MODE_WRAP)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    register_addr_ctr #(
        .WIDTH         (16),
        .DEFAULT_VALUE (16'hFFFC),
        .STEP          (4),
        .OFFSET_WIDTH  (8),
        .SATURATE      (MODE_SAT)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_v0(input string tag, input logic [15:0] v, input logic o);
        chk({tag, ".addr0"}, {16'h0, bus0.addr_out}, {16'h0, v});
        chk({tag, ".xfer0"}, {16'h0, bus0.xfer_out}, {16'h0, v});
        chk({tag, ".ovf0"},  {31'h0, bus0.ovf},      {31'h0, o});
    endtask

    task automatic chk_v1(input string tag, input logic [15:0] v, input logic o);
        chk({tag, ".addr1"}, {16'h0, bus1.addr_out}, {16'h0, v});
        chk({tag, ".xfer1"}, {16'h0, bus1.xfer_out}, {16'h0, v});
        chk({tag, ".ovf1"},  {31'h0, bus1.ovf},      {31'h0, o});
    endtask

    task automatic idle();
        bus0.load_xfer = 1'b1; bus0.add_off = 1'b1; bus0.inc = 1'b1;
        bus0.dec = 1'b1; bus0.clr_ovf = 1'b1;
        bus1.load_xfer = 1'b1; bus1.add_off = 1'b1; bus1.inc = 1'b1;
        bus1.dec = 1'b1; bus1.clr_ovf = 1'b1;
`ifdef REGISTER_ADDR_SHADOW_EN
        bus0.save = 1'b1; bus0.restore = 1'b1;
        bus1.save = 1'b1; bus1.restore = 1'b1;
`endif
    endtask

    // One edge: rotate the bus-drive requests, sample 1 time unit after the
    // edge, check the enables against the requests just driven, then idle.
    task automatic tick();
        logic a0, x0;
        a0 = en_pat[0];
        x0 = en_pat[1];
        bus0.assert_addr = a0;
        bus0.assert_xfer = x0;
        bus1.assert_addr = x0;
        bus1.assert_xfer = a0;
        @(posedge clk);
        #1;
        chk("addr_en0", {31'h0, bus0.addr_en}, {31'h0, ~a0});
        chk("xfer_en0", {31'h0, bus0.xfer_en}, {31'h0, ~x0});
        chk("addr_en1", {31'h0, bus1.addr_en}, {31'h0, ~x0});
        chk("xfer_en1", {31'h0, bus1.xfer_en}, {31'h0, ~a0});
        en_pat++;
        idle();
    endtask

    // Active-low controls: ld, ad, in, de, cl.
    task automatic cyc0(input logic ld, input logic ad, input logic in, input logic de,
                        input logic cl, input logic [15:0] x, input logic [7:0] off);
        bus0.load_xfer = ld; bus0.add_off = ad; bus0.inc = in; bus0.dec = de;
        bus0.clr_ovf = cl; bus0.xfer_in = x; bus0.offset_in = off;
        tick();
    endtask

    task automatic cyc1(input logic ld, input logic ad, input logic in, input logic de,
                        input logic cl, input logic [15:0] x, input logic [7:0] off);
        bus1.load_xfer = ld; bus1.add_off = ad; bus1.inc = in; bus1.dec = de;
        bus1.clr_ovf = cl; bus1.xfer_in = x; bus1.offset_in = off;
        tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        en_pat = 0;
        idle();
        bus0.xfer_in = '0; bus0.offset_in = '0;
        bus1.xfer_in = '0; bus1.offset_in = '0;
        bus0.assert_addr = 1'b1; bus0.assert_xfer = 1'b1;
        bus1.assert_addr = 1'b1; bus1.assert_xfer = 1'b1;
        reset = 1'b1;

        // Reset values before any clock edge
        #2;
        chk_v0("reset", 16'h0000, 1'b0);
        chk_v1("reset", 16'hFFFC, 1'b0);
        #1 reset = 1'b0;

        // Wrap mode, STEP=1
        cyc0(0, 1, 1, 1, 1, 16'hFFFF, 8'h00); chk_v0("load_ffff", 16'hFFFF, 1'b0);
        cyc0(1, 1, 0, 1, 1, 16'h0000, 8'h00); chk_v0("wrap_inc",  16'h0000, 1'b1);
        cyc0(1, 1, 1, 1, 0, 16'h0000, 8'h00); chk_v0("clr_ovf",   16'h0000, 1'b0);
        cyc0(1, 1, 1, 0, 1, 16'h0000, 8'h00); chk_v0("wrap_dec",  16'hFFFF, 1'b1);
        cyc0(1, 1, 1, 1, 0, 16'h0000, 8'h00); chk_v0("clr_ovf2",  16'hFFFF, 1'b0);
        cyc0(1, 1, 0, 1, 0, 16'h0000, 8'h00); chk_v0("set_wins",  16'h0000, 1'b1);
        cyc0(1, 1, 1, 1, 1, 16'h0000, 8'h00); chk_v0("ovf_stick", 16'h0000, 1'b1);
        cyc0(0, 1, 1, 1, 0, 16'h1000, 8'h00); chk_v0("load_clr",  16'h1000, 1'b0);

        // Relative add
        cyc0(1, 0, 1, 1, 1, 16'h0000, 8'hF0); chk_v0("add_neg",   16'h0FF0, 1'b0);
        cyc0(1, 0, 1, 1, 1, 16'h0000, 8'h7F); chk_v0("add_pos",   16'h106F, 1'b0);
        cyc0(1, 0, 1, 1, 1, 16'h0000, 8'h00); chk_v0("add_zero",  16'h106F, 1'b0);
        cyc0(0, 1, 1, 1, 1, 16'h0005, 8'h00); chk_v0("load_5",    16'h0005, 1'b0);
        cyc0(1, 0, 1, 1, 1, 16'h0000, 8'hF0); chk_v0("add_under", 16'hFFF5, 1'b1);
        cyc0(1, 1, 1, 1, 0, 16'h0000, 8'h00); chk_v0("clr_ovf3",  16'hFFF5, 1'b0);

        // Priority
        cyc0(0, 0, 0, 0, 1, 16'h1234, 8'h02); chk_v0("pri_load",  16'h1234, 1'b0);
        cyc0(1, 0, 0, 0, 1, 16'h0000, 8'h02); chk_v0("pri_add",   16'h1236, 1'b0);
        cyc0(0, 1, 1, 1, 1, 16'h0010, 8'h00); chk_v0("load_10",   16'h0010, 1'b0);
        cyc0(1, 1, 0, 0, 1, 16'h0000, 8'h00); chk_v0("pri_inc",   16'h0011, 1'b0);
        cyc0(1, 1, 1, 0, 1, 16'h0000, 8'h00); chk_v0("dec_only",  16'h0010, 1'b0);
        cyc0(1, 1, 1, 1, 1, 16'hBEEF, 8'h55); chk_v0("hold",      16'h0010, 1'b0);

        // Saturate mode, STEP=4
        cyc1(0, 1, 1, 1, 1, 16'h0002, 8'h00); chk_v1("load_2",    16'h0002, 1'b0);
        cyc1(1, 1, 1, 0, 1, 16'h0000, 8'h00); chk_v1("sat_dec",   16'h0000, 1'b1);
        cyc1(0, 1, 1, 1, 0, 16'hFFFE, 8'h00); chk_v1("load_fffe", 16'hFFFE, 1'b0);
        cyc1(1, 1, 0, 1, 1, 16'h0000, 8'h00); chk_v1("sat_inc",   16'hFFFF, 1'b1);
        cyc1(0, 1, 1, 1, 0, 16'hFFF0, 8'h00); chk_v1("load_fff0", 16'hFFF0, 1'b0);
        cyc1(1, 0, 1, 1, 1, 16'h0000, 8'h7F); chk_v1("sat_addup", 16'hFFFF, 1'b1);
        cyc1(0, 1, 1, 1, 0, 16'h0010, 8'h00); chk_v1("load_10",   16'h0010, 1'b0);
        cyc1(1, 1, 1, 0, 1, 16'h0000, 8'h00); chk_v1("dec4",      16'h000C, 1'b0);
        cyc1(1, 1, 0, 1, 1, 16'h0000, 8'h00); chk_v1("inc4",      16'h0010, 1'b0);
        cyc1(1, 0, 1, 1, 1, 16'h0000, 8'h80); chk_v1("sat_adddn", 16'h0000, 1'b1);

`ifdef REGISTER_ADDR_SHADOW_EN
        // Shadow save/restore on dut0 (value 16'h0010, ovf 0 here)
        cyc0(0, 1, 1, 1, 1, 16'h0200, 8'h00); chk_v0("load_200",  16'h0200, 1'b0);
        bus0.save = 1'b0;
        cyc0(1, 1, 0, 1, 1, 16'h0000, 8'h00); chk_v0("save_inc",  16'h0201, 1'b0);
        chk("shadow", {16'h0, dut0.r_shadow}, {16'h0, 16'h0200});
        cyc0(0, 1, 1, 1, 1, 16'h5555, 8'h00); chk_v0("load_5555", 16'h5555, 1'b0);
        bus0.restore = 1'b0;
        cyc0(1, 0, 0, 1, 1, 16'h0000, 8'h01); chk_v0("restore",   16'h0200, 1'b0);
        bus0.restore = 1'b0;
        cyc0(0, 1, 1, 1, 1, 16'h7777, 8'h00); chk_v0("load_ovr",  16'h7777, 1'b0);
        cyc0(0, 1, 1, 1, 1, 16'hFFFF, 8'h00);
        cyc0(1, 1, 0, 1, 1, 16'h0000, 8'h00); chk_v0("ovf_pre",   16'h0000, 1'b1);
        bus0.restore = 1'b0;
        cyc0(1, 1, 1, 1, 1, 16'h0000, 8'h00); chk_v0("rest_ovf",  16'h0200, 1'b1);
        cyc0(1, 1, 1, 1, 0, 16'h0000, 8'h00); chk_v0("clr_ovf4",  16'h0200, 1'b0);
`endif

        // Asynchronous reset mid-operation (dut1 has ovf=1, value 0)
        cyc1(0, 1, 1, 1, 1, 16'h4321, 8'h00); chk_v1("load_4321", 16'h4321, 1'b1);
        reset = 1'b1;
        #2;
        chk_v1("async_rst", 16'hFFFC, 1'b0);
        chk_v0("async_rst", 16'h0000, 1'b0);
        #1 reset = 1'b0;
        cyc1(1, 1, 0, 1, 1, 16'h0000, 8'h00); chk_v1("post_rst",  16'hFFFF, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
